instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory address.
- Captures the combinational instruction word returned by the memory into the IF/ID pipeline register for the decoder.
- Handles stall, branch/jump redirect (with flush) and halt detection.

Parameters:
ADDR_W, 16, program counter / memory address width
DATA_W, 16, instruction word width
RESET_VECTOR, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0000, bubble encoding written to IF/ID on flush/idle
HALT_INSTR, 16'hFFFF, encoding that stops fetching

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
pc_out  output  ADDR_W  current PC; drives the instruction memory address
instr_in  input  DATA_W  instruction from memory for pc_out (combinational, same cycle)
stall  input  1  hold PC and IF/ID contents
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  ADDR_W  new PC when redirect_valid=1
ifid_instr  output  DATA_W  registered instruction to decoder
ifid_pc  output  ADDR_W  PC of ifid_instr
ifid_valid  output  1  ifid_instr is a real instruction (0 = bubble)
halted  output  1  fetch stopped on HALT_INSTR

Behaviour:
- Reset (async, immediate):
  - pc_out=RESET_VECTOR, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_valid=0, halted=0.
  - State=BOOT.
- States are BOOT, RUN and HALT. All updates occur on the rising clk edge.
- BOOT:
  - Exactly one cycle after reset release; lets the memory output settle.
  - pc_out held, ifid_valid=0, then go to RUN.
  - stall and redirect are ignored in BOOT.
- RUN, priority redirect > stall > normal:
  - redirect_valid=1: pc_out<=redirect_target; ifid_instr<=NOP_INSTR; ifid_valid<=0. Overrides stall. Current instr_in is discarded.
  - stall=1 (no redirect): pc_out, ifid_instr, ifid_pc and ifid_valid all hold.
  - Normal: ifid_instr<=instr_in; ifid_pc<=pc_out; ifid_valid<=1; pc_out<=pc_out+1, modulo 2^ADDR_W (16'hFFFF wraps to 16'h0000, no flag).
  - Normal with instr_in==HALT_INSTR: the halt word is latched as a valid instruction, pc_out does NOT increment, state<=HALT, halted<=1.
- HALT:
  - pc_out held.
  - stall=1: IF/ID holds.
  - Otherwise: ifid_instr<=NOP_INSTR and ifid_valid<=0 (the halt word is presented for one unstalled cycle only).
  - redirect_valid=1: pc_out<=redirect_target, halted<=0, ifid_valid<=0, state<=RUN. Redirect has priority over stall, as in RUN.
- Latency: instruction at address N appears on ifid_instr one cycle after pc_out==N with no stall or redirect.
- Steady-state throughput is one instruction per clock.
- Simultaneous stall and redirect: redirect wins and the bubble is inserted.
- Reset asserted mid-operation: all state is lost immediately, with no completion of the in-flight fetch.

Test Plan:
1. Reset start-up:
   - Stimulus: memory 0:16'h1234, 1:16'h5678, 2:16'h9ABC; release rst.
   - Required: BOOT cycle with pc_out=0 and ifid_valid=0.
   - Then ifid_instr = 1234/5678/9ABC on successive cycles with ifid_pc=0/1/2, ifid_valid=1, pc_out=1/2/3.
2. Stall:
   - Stimulus: stall=1 for 3 cycles while pc_out=2.
   - Required: pc_out stays 2 and ifid_instr stays 16'h5678 (ifid_pc=1) for 3 cycles.
   - After release: ifid_instr=16'h9ABC, pc_out=3.
3. Redirect:
   - Stimulus: redirect_valid=1, redirect_target=16'h0040, together with stall=1, at pc_out=3.
   - Required: next cycle pc_out=16'h0040, ifid_valid=0, ifid_instr=16'h0000.
   - Following cycle: ifid_pc=16'h0040, ifid_valid=1.
4. Halt and wake:
   - Stimulus: memory 5:16'hFFFF; run to it.
   - Required: ifid_instr=16'hFFFF valid for one cycle, halted=1, pc_out stays 5, then ifid_valid=0 indefinitely.
   - Then redirect to 0: halted=0, fetch resumes at 0.
5. Wrap-around:
   - Stimulus: redirect to 16'hFFFE; memory returns non-halt words.
   - Required: pc_out sequence FFFE, FFFF, 0000, 0001; ifid_pc follows one cycle later.
6. Async reset mid-run:
   - Stimulus: assert rst between clock edges at pc_out=16'h0041.
   - Required: pc_out=0, ifid_valid=0, halted=0 immediately, before the next edge; BOOT again after release.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
// Owns the program counter, drives the instruction memory address and captures
// the combinational memory word into the IF/ID pipeline register.
// Handles stall, branch/jump redirect with flush, and halt detection.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   pc_out          current PC, instruction memory address
//   instr_in        memory word for pc_out (same cycle)
//   stall           hold PC and IF/ID
//   redirect_valid  taken branch/jump this cycle
//   redirect_target new PC when redirect_valid is high
//   ifid_instr      registered instruction to decode
//   ifid_pc         PC of ifid_instr
//   ifid_valid      ifid_instr is a real instruction (0 = bubble)
//   halted          fetch stopped on the halt encoding
module instruction_fetch #(
    parameter int unsigned        ADDR_W       = 16,
    parameter int unsigned        DATA_W       = 16,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = 16'h0000,
    parameter logic [DATA_W-1:0]  NOP_INSTR    = 16'h0000,
    parameter logic [DATA_W-1:0]  HALT_INSTR   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc_out,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic              ifid_valid,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [DATA_W-1:0]  ifid_instr_q;
    logic [ADDR_W-1:0]  ifid_pc_q;
    logic               ifid_valid_q;
    logic               halted_q;

    // Fetch control: redirect beats stall beats normal fetch in RUN and HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                // One settle cycle for the memory after reset; inputs ignored.
                ST_BOOT: begin
                    ifid_valid_q <= 1'b0;
                    state_q      <= ST_RUN;
                end

                ST_RUN: begin
                    if (redirect_valid) begin
                        pc_q         <= redirect_target;
                        ifid_instr_q <= NOP_INSTR;
                        ifid_valid_q <= 1'b0;
                    end else if (!stall) begin
                        ifid_instr_q <= instr_in;
                        ifid_pc_q    <= pc_q;
                        ifid_valid_q <= 1'b1;
                        // The halt word is passed on as valid but the PC parks on it.
                        if (instr_in == HALT_INSTR) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q <= pc_q + ADDR_W'(1);
                        end
                    end
                end

                ST_HALT: begin
                    if (redirect_valid) begin
                        pc_q         <= redirect_target;
                        ifid_instr_q <= NOP_INSTR;
                        ifid_valid_q <= 1'b0;
                        halted_q     <= 1'b0;
                        state_q      <= ST_RUN;
                    end else if (!stall) begin
                        // Halt word shown for one unstalled cycle, bubbles after.
                        ifid_instr_q <= NOP_INSTR;
                        ifid_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    assign pc_out     = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_valid = ifid_valid_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed start-up, stall,
// redirect, halt/wake, wrap-around and async reset scenarios, then a
// randomized stall/redirect run, all against a behavioural fetch model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_out;
    logic [15:0] instr_in;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        halted;

    instruction_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .pc_out          (pc_out),
        .instr_in        (instr_in),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_valid      (ifid_valid),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory image
    logic [15:0] mem [0:65535];

    int total = 0;
    int bad   = 0;

    // Behavioural model of the fetch stage
    logic [15:0] m_pc, m_instr, m_ipc;
    logic        m_valid, m_halt, m_boot;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},     32'(pc_out),     32'(m_pc));
        check({tag, ".instr"},  32'(ifid_instr), 32'(m_instr));
        check({tag, ".ipc"},    32'(ifid_pc),    32'(m_ipc));
        check({tag, ".valid"},  32'(ifid_valid), 32'(m_valid));
        check({tag, ".halted"}, 32'(halted),     32'(m_halt));
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
        m_valid = 1'b0;  m_halt = 1'b0;     m_boot = 1'b1;
    endtask

    // One clock of fetch behaviour, expressed directly from the stage rules
    task automatic model_step(input logic st, input logic rv, input logic [15:0] tgt);
        logic [15:0] w;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (rv) begin
            m_pc = tgt; m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
        end else if (st) begin
            // everything holds
        end else if (m_halt) begin
            m_instr = 16'h0000; m_valid = 1'b0;
        end else begin
            w = mem[m_pc];
            m_instr = w; m_ipc = m_pc; m_valid = 1'b1;
            if (w == 16'hFFFF) m_halt = 1'b1;
            else               m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic cycle(input string tag, input logic st, input logic rv, input logic [15:0] tgt);
        stall = st; redirect_valid = rv; redirect_target = tgt;
        model_step(st, rv, tgt);
        @(posedge clk);
        #1;
        stall = 1'b0; redirect_valid = 1'b0;
        instr_in = mem[pc_out];
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
        instr_in = 16'h0000;

        // Non-halt random memory, a sprinkling of halts, then directed words
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom_range(0, 16'hFFFE));
        for (int a = 100; a < 400; a++) if ($urandom_range(0, 19) == 0) mem[a] = 16'hFFFF;
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[5] = 16'hFFFF;

        // 1. reset start-up
        model_reset();
        @(posedge clk); #1;
        check_all("reset");
        rst = 1'b0;
        instr_in = mem[pc_out];
        cycle("boot", 1'b0, 1'b0, 16'h0);
        check("boot.valid_const", 32'(ifid_valid), 32'd0);
        cycle("run0", 1'b0, 1'b0, 16'h0);
        check("run0.instr_const", 32'(ifid_instr), 32'h1234);
        cycle("run1", 1'b0, 1'b0, 16'h0);
        check("run1.pc_const", 32'(pc_out), 32'd2);

        // 2. stall for three cycles at pc 2
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1'b1, 1'b0, 16'h0);
            check("stall.instr_const", 32'(ifid_instr), 32'h5678);
        end
        cycle("unstall", 1'b0, 1'b0, 16'h0);
        check("unstall.instr_const", 32'(ifid_instr), 32'h9ABC);

        // 3. redirect together with stall
        cycle("redir", 1'b1, 1'b1, 16'h0040);
        check("redir.pc_const", 32'(pc_out), 32'h0040);
        cycle("redir_next", 1'b0, 1'b0, 16'h0);
        check("redir_next.ipc_const", 32'(ifid_pc), 32'h0040);

        // 6. async reset between edges at pc 0x41
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst = 1'b0;
        instr_in = mem[pc_out];
        cycle("reboot", 1'b0, 1'b0, 16'h0);

        // 4. run to the halt word at address 5 and wake
        for (int i = 0; i < 6; i++) cycle("to_halt", 1'b0, 1'b0, 16'h0);
        check("halt.instr_const", 32'(ifid_instr), 32'hFFFF);
        check("halt.flag_const", 32'(halted), 32'd1);
        cycle("halt_stall", 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) cycle("halted", 1'b0, 1'b0, 16'h0);
        check("halted.pc_const", 32'(pc_out), 32'd5);
        cycle("wake", 1'b1, 1'b1, 16'h0000);
        check("wake.halted_const", 32'(halted), 32'd0);
        cycle("resume0", 1'b0, 1'b0, 16'h0);
        cycle("resume1", 1'b0, 1'b0, 16'h0);

        // 5. wrap-around from 0xFFFE
        cycle("wrap_redir", 1'b0, 1'b1, 16'hFFFE);
        for (int i = 0; i < 4; i++) cycle("wrap", 1'b0, 1'b0, 16'h0);
        check("wrap.pc_const", 32'(pc_out), 32'h0002);

        // Randomized stall/redirect traffic
        for (int i = 0; i < 400; i++) begin
            logic st, rv;
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 9) == 0);
            cycle("rand", st, rv, 16'($urandom_range(0, 400)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
